imem_loadable: RTL and testbench

Parametrised, run-time loadable instruction memory for the single-cycle core. Words are streamed in through a valid/ready program port with an auto-incrementing write pointer, and the core fetches them through a registered one-cycle read port. The block tracks how many words are loaded and flags fetches that fall outside the loaded program. It replaces fixed reset-time program contents with a load/run control state machine.

---
 rtl/imem_loadable.sv | 95 +++++++++
 tb/tb_imem_loadable.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loadable.sv
// Run-time loadable instruction memory: streamed program port, registered fetch port, IDLE/LOAD/RUN control.
// Latency: fetch response one cycle after fetch_req; state/ready/running change one cycle after the sampling edge.
// Backpressure: prog_ready is high only in LOAD; the fetch port has none (one response per request, every cycle).
module imem_loadable #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_start,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ready,
    input  logic              prog_done,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_err,
    output logic              running,
    output logic [ADDR_W:0]   load_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              accept;
    logic              fetch_ok;

    // A restart in the same cycle always wins over a program beat.
    assign accept   = prog_valid && prog_ready && !prog_start;
    assign fetch_ok = running && ({1'b0, fetch_addr} < load_count);

    // Program storage is deliberately not reset; only the loaded range is ever fetchable.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            mem[ptr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            load_count  <= '0;
            prog_ready  <= 1'b0;
            running     <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_data  <= '0;
            fetch_err   <= 1'b0;
        end else begin
            if (prog_start) begin
                state      <= LOAD;
                ptr        <= '0;
                load_count <= '0;
                prog_ready <= 1'b1;
                running    <= 1'b0;
            end else if (state == LOAD) begin
                if (accept) begin
                    ptr        <= (ptr == LAST_PTR) ? ptr : ptr + 1'b1;
                    load_count <= load_count + 1'b1;
                end
                if (prog_done || (accept && ptr == LAST_PTR)) begin
                    state      <= RUN;
                    prog_ready <= 1'b0;
                    running    <= 1'b1;
                end
            end

            // Validity uses the registered running/load_count of the request cycle.
            fetch_valid <= fetch_req;
            if (fetch_req) begin
                if (fetch_ok) begin
                    fetch_data <= mem[fetch_addr];
                    fetch_err  <= 1'b0;
                end else begin
                    fetch_data <= '0;
                    fetch_err  <= 1'b1;
                end
            end else begin
                fetch_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imem_loadable.sv
// Directed bench for imem_loadable with a small DEPTH; expected values are hand-computed constants.
module tb_imem_loadable;

    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic          clk;
    logic          rst;
    logic          prog_start;
    logic          prog_valid;
    logic [31:0]   prog_data;
    logic          prog_ready;
    logic          prog_done;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_valid;
    logic [31:0]   fetch_data;
    logic          fetch_err;
    logic          running;
    logic [AW:0]   load_count;

    int n_chk = 0;
    int n_err = 0;

    imem_loadable #(.DATA_W(32), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .prog_start  (prog_start),
        .prog_valid  (prog_valid),
        .prog_data   (prog_data),
        .prog_ready  (prog_ready),
        .prog_done   (prog_done),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .fetch_err   (fetch_err),
        .running     (running),
        .load_count  (load_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string tag, input int addr, input logic [31:0] exp_data, input logic exp_err);
        fetch_req  = 1'b1;
        fetch_addr = AW'(addr);
        tick();
        check({tag, ".vld"}, 64'(fetch_valid), 64'd1);
        check({tag, ".dat"}, 64'(fetch_data), 64'(exp_data));
        check({tag, ".err"}, 64'(fetch_err), 64'(exp_err));
    endtask

    task automatic beat(input logic [31:0] d);
        prog_valid = 1'b1;
        prog_data  = d;
        tick();
        prog_valid = 1'b0;
    endtask

    task automatic start_load();
        prog_start = 1'b1;
        tick();
        prog_start = 1'b0;
    endtask

    task automatic state_chk(input string tag, input logic rdy, input logic run, input int cnt);
        check({tag, ".rdy"}, 64'(prog_ready), 64'(rdy));
        check({tag, ".run"}, 64'(running), 64'(run));
        check({tag, ".cnt"}, 64'(load_count), 64'(cnt));
    endtask

    initial begin
        rst = 1'b1; prog_start = 1'b0; prog_valid = 1'b0; prog_data = '0;
        prog_done = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
        tick();
        tick();
        rst = 1'b0;
        state_chk("reset", 1'b0, 1'b0, 0);
        check("reset.fvld", 64'(fetch_valid), 64'd0);
        check("reset.fdat", 64'(fetch_data), 64'd0);
        check("reset.ferr", 64'(fetch_err), 64'd0);

        fetch("idle_f0", 0, 32'h0, 1'b1);
        fetch_req = 1'b0;
        tick();
        check("idle_noreq.vld", 64'(fetch_valid), 64'd0);

        // Four-word load closed by prog_done.
        start_load();
        state_chk("load4_start", 1'b1, 1'b0, 0);
        for (int i = 0; i < 4; i++) beat(32'h1111_1111 * (i + 1));
        state_chk("load4_beats", 1'b1, 1'b0, 4);
        prog_done = 1'b1;
        tick();
        prog_done = 1'b0;
        state_chk("load4_done", 1'b0, 1'b1, 4);
        for (int i = 0; i < 4; i++) fetch($sformatf("b2b_f%0d", i), i, 32'h1111_1111 * (i + 1), 1'b0);
        fetch_req = 1'b0;
        tick();
        check("hold.vld", 64'(fetch_valid), 64'd0);
        check("hold.err", 64'(fetch_err), 64'd0);
        check("hold.dat", 64'(fetch_data), 64'h4444_4444);
        fetch("oob_f4", 4, 32'h0, 1'b1);
        fetch_req = 1'b0;

        // Full-depth load with prog_valid held: auto transition on the last beat.
        start_load();
        prog_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            prog_data = 32'hA000_0000 + 32'(i);
            tick();
            if (i == DEPTH - 2) state_chk("full_penult", 1'b1, 1'b0, DEPTH - 1);
        end
        state_chk("full_last", 1'b0, 1'b1, DEPTH);
        prog_data = 32'h0BAD_0BAD;
        tick();
        prog_valid = 1'b0;
        state_chk("full_extra", 1'b0, 1'b1, DEPTH);
        fetch("full_flast", DEPTH - 1, 32'hA000_0000 + 32'(DEPTH - 1), 1'b0);
        fetch("full_f0", 0, 32'hA000_0000, 1'b0);
        fetch_req = 1'b0;

        // Restart mid-load; the beat coinciding with prog_start is dropped.
        start_load();
        for (int i = 0; i < 3; i++) beat(32'hC000_0000 + 32'(i));
        state_chk("restart_pre", 1'b1, 1'b0, 3);
        prog_start = 1'b1;
        prog_valid = 1'b1;
        prog_data  = 32'hEEEE_EEEE;
        tick();
        prog_start = 1'b0;
        prog_valid = 1'b0;
        state_chk("restart", 1'b1, 1'b0, 0);
        beat(32'h5555_0000);
        prog_done = 1'b1;
        beat(32'h5555_0001);
        prog_done = 1'b0;
        state_chk("restart_done", 1'b0, 1'b1, 2);
        fetch("restart_f0", 0, 32'h5555_0000, 1'b0);
        fetch("restart_f1", 1, 32'h5555_0001, 1'b0);
        fetch("restart_f2", 2, 32'h0, 1'b1);
        fetch_req = 1'b0;

        // Reload from RUN; fetches during LOAD and alongside prog_done err.
        start_load();
        state_chk("reload_start", 1'b1, 1'b0, 0);
        fetch("reload_inload", 0, 32'h0, 1'b1);
        fetch_req = 1'b0;
        beat(32'hDEAD_BEEF);
        prog_done = 1'b1;
        fetch("reload_atdone", 0, 32'h0, 1'b1);
        prog_done = 1'b0;
        state_chk("reload_done", 1'b0, 1'b1, 1);
        fetch("reload_f0", 0, 32'hDEAD_BEEF, 1'b0);
        fetch("reload_f1", 1, 32'h0, 1'b1);
        fetch_req = 1'b0;

        // prog_done with nothing loaded: RUN, but every fetch errs.
        start_load();
        prog_done = 1'b1;
        tick();
        prog_done = 1'b0;
        state_chk("empty_done", 1'b0, 1'b1, 0);
        fetch("empty_f0", 0, 32'h0, 1'b1);
        fetch_req = 1'b0;

        // Reset alongside a fetch in RUN suppresses the response.
        start_load();
        beat(32'h1234_5678);
        prog_done = 1'b1;
        tick();
        prog_done = 1'b0;
        fetch("pre_rst_f0", 0, 32'h1234_5678, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fetch_req = 1'b0;
        check("rst_fetch.vld", 64'(fetch_valid), 64'd0);
        check("rst_fetch.dat", 64'(fetch_data), 64'd0);
        check("rst_fetch.err", 64'(fetch_err), 64'd0);
        state_chk("rst_fetch", 1'b0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
